register_nbit_shift: RTL

REGISTER_NBIT_SHIFT -- requirements
Module: register_nbit_shift

---
 rtl/register_nbit_shift.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/register_nbit_shift.sv
`default_nettype none
// ============================================================================
//  Module   : register_nbit_shift
//  Purpose  : WIDTH-bit register that can be parallel-loaded or shifted by a
//             multi-cycle amount (logical left, logical right, rotate right),
//             one bit position per enabled clock edge. A three-state FSM
//             (IDLE / SHIFT / DONE) sequences each operation.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk     in   1      rising-edge clock
//    reset   in   1      asynchronous active-low reset
//    en      in   1      global enable; 0 freezes all state
//    start   in   1      request a new operation (sampled in IDLE only)
//    op      in   2      00 LOAD, 01 SLL, 10 SRL, 11 ROR
//    amount  in   AMT_W  shift count, captured with start
//    din     in   WIDTH  parallel load data
//    sin     in   1      serial fill bit for SLL/SRL
//    abort   in   1      (REG_SHIFT_ABORT_EN only) cancel a running shift
//    dout    out  WIDTH  register contents
//    sout    out  1      bit most recently shifted out
//    busy    out  1      high while shifting
//    done    out  1      one-cycle completion pulse
//  Configuration macro
//    REG_SHIFT_ABORT_EN  adds the abort input
// ============================================================================
module register_nbit_shift #(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
`ifdef REG_SHIFT_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [AMT_W-1:0]   count, count_nx;
  logic [1:0]         op_q, op_nx;
  logic [WIDTH-1:0]   dout_nx;
  logic               sout_nx;
  logic [WIDTH-1:0]   shift_dout;
  logic               shift_sout;

  // Single-position shift of the current contents using the latched op.
  always_comb begin
    shift_dout = dout;
    shift_sout = sout;
    case (op_q)
      OP_SLL: begin
        shift_dout = {dout[WIDTH-2:0], sin};
        shift_sout = dout[WIDTH-1];
      end
      OP_SRL: begin
        shift_dout = {sin, dout[WIDTH-1:1]};
        shift_sout = dout[0];
      end
      OP_ROR: begin
        shift_dout = {dout[0], dout[WIDTH-1:1]};
        shift_sout = dout[0];
      end
      default: begin
        shift_dout = dout;
        shift_sout = sout;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    op_nx    = op_q;
    dout_nx  = dout;
    sout_nx  = sout;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_LOAD) begin
            dout_nx  = din;
            state_nx = S_DONE;
          end else if (amount == '0) begin
            state_nx = S_DONE;
          end else begin
            // Accept edge only latches the request; shifting starts next edge.
            count_nx = amount;
            op_nx    = op;
            state_nx = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
`ifdef REG_SHIFT_ABORT_EN
        if (abort) begin
          state_nx = S_IDLE;
        end else
`endif
        begin
          dout_nx  = shift_dout;
          sout_nx  = shift_sout;
          count_nx = count - AMT_W'(1);
          if (count == AMT_W'(1)) begin
            state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= '0;
      op_q  <= OP_LOAD;
      dout  <= '0;
      sout  <= 1'b0;
    end else if (en) begin
      state <= state_nx;
      count <= count_nx;
      op_q  <= op_nx;
      dout  <= dout_nx;
      sout  <= sout_nx;
    end
  end

  // Decoded straight from the state register, so both are glitch-free
  // registered outputs and freeze together with the FSM when en=0.
  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule
`default_nettype wire
